// File: rtl/frame_copy_dma.sv
// rtl/frame_copy_dma.sv - pipelined frame RAM to VRAM copy engine with GPU draw trigger
module frame_copy_dma #(
    parameter int FRAME_W = 11,
    parameter int DATA_W  = 16,
    parameter int VADDR_W = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 FRAME_SEL,
    input  logic                 ABORT,
    input  logic                 GPU_READY,
    input  logic [DATA_W-1:0]    RAM_DATA_R,
    output logic                 RAM_EN,
    output logic [FRAME_W:0]     RAM_ADDR,
    output logic                 VRAM_EN,
    output logic                 VRAM_WE,
    output logic [VADDR_W-1:0]   VRAM_ADDR,
    output logic [DATA_W-1:0]    VRAM_DATA_W,
    output logic                 GPU_DRAW,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 SKIPPED,
    output logic                 ABORTED,
    output logic                 LAST_FRAME
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_STREAM,
        S_DRAIN1,
        S_DRAIN2,
        S_FINISH
    } state_t;

    state_t              state;
    state_t              state_nx;

    logic                frame;
    logic [FRAME_W-1:0]  rd_cnt;
    logic                rd_valid;   // read issued last cycle, data on RAM_DATA_R now
    logic [FRAME_W-1:0]  rd_word;
    logic                wr_valid;   // captured word is being written this cycle
    logic [FRAME_W-1:0]  wr_word;
    logic [DATA_W-1:0]   wr_data;
    logic                last_frame_q;

    logic                abort_now;
    logic                issue;

    // ABORT only matters while a copy is in flight; it also kills this cycle's accesses
    assign abort_now = ABORT && (state == S_CHECK || state == S_STREAM ||
                                 state == S_DRAIN1 || state == S_DRAIN2);
    assign issue     = (state == S_STREAM) && !ABORT;

    assign RAM_EN      = issue;
    assign RAM_ADDR    = {frame, rd_cnt};
    assign VRAM_EN     = wr_valid && !abort_now;
    assign VRAM_WE     = wr_valid && !abort_now;
    assign VRAM_ADDR   = {{(VADDR_W-FRAME_W){1'b0}}, wr_word};
    assign VRAM_DATA_W = wr_data;
    assign BUSY        = (state != S_IDLE);
    assign LAST_FRAME  = last_frame_q;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and completion strobes; ABORT has priority over every other exit
    always_comb begin
        state_nx = state;
        DONE     = 1'b0;
        SKIPPED  = 1'b0;
        ABORTED  = 1'b0;
        GPU_DRAW = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (ABORT) begin
                    state_nx = S_IDLE;
                    DONE     = 1'b1;
                    ABORTED  = 1'b1;
                end else if (GPU_READY) begin
                    state_nx = S_STREAM;
                end else begin
                    state_nx = S_IDLE;
                    DONE     = 1'b1;
                    SKIPPED  = 1'b1;
                end
            end
            S_STREAM: begin
                if (ABORT) begin
                    state_nx = S_IDLE;
                    DONE     = 1'b1;
                    ABORTED  = 1'b1;
                end else if (rd_cnt == {FRAME_W{1'b1}}) begin
                    state_nx = S_DRAIN1;
                end
            end
            S_DRAIN1, S_DRAIN2: begin
                if (ABORT) begin
                    state_nx = S_IDLE;
                    DONE     = 1'b1;
                    ABORTED  = 1'b1;
                end else begin
                    state_nx = (state == S_DRAIN1) ? S_DRAIN2 : S_FINISH;
                end
            end
            S_FINISH: begin
                state_nx = S_IDLE;
                DONE     = 1'b1;
                GPU_DRAW = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Read counter, read/write shift pair and captured write data
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame        <= 1'b0;
            rd_cnt       <= '0;
            rd_valid     <= 1'b0;
            rd_word      <= '0;
            wr_valid     <= 1'b0;
            wr_word      <= '0;
            wr_data      <= '0;
            last_frame_q <= 1'b0;
        end else begin
            if (state == S_IDLE && START) begin
                frame  <= FRAME_SEL;
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + FRAME_W'(1);
            end

            if (issue) rd_word <= rd_cnt;
            rd_valid <= issue;

            if (abort_now) begin
                wr_valid <= 1'b0;
            end else begin
                wr_valid <= rd_valid;
                if (rd_valid) begin
                    wr_word <= rd_word;
                    wr_data <= RAM_DATA_R;
                end
            end

            if (state == S_FINISH) last_frame_q <= frame;
        end
    end

endmodule

// File: tb/tb_frame_copy_dma.sv
// tb/tb_frame_copy_dma.sv - directed self-checking bench for frame_copy_dma
module tb_frame_copy_dma;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic        FRAME_SEL;
    logic        ABORT;
    logic        GPU_READY;
    logic [15:0] RAM_DATA_R;
    logic        RAM_EN;
    logic [11:0] RAM_ADDR;
    logic        VRAM_EN;
    logic        VRAM_WE;
    logic [15:0] VRAM_ADDR;
    logic [15:0] VRAM_DATA_W;
    logic        GPU_DRAW;
    logic        BUSY;
    logic        DONE;
    logic        SKIPPED;
    logic        ABORTED;
    logic        LAST_FRAME;

    frame_copy_dma #(.FRAME_W(11), .DATA_W(16), .VADDR_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FRAME_SEL(FRAME_SEL),
        .ABORT(ABORT), .GPU_READY(GPU_READY), .RAM_DATA_R(RAM_DATA_R),
        .RAM_EN(RAM_EN), .RAM_ADDR(RAM_ADDR), .VRAM_EN(VRAM_EN),
        .VRAM_WE(VRAM_WE), .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA_W(VRAM_DATA_W),
        .GPU_DRAW(GPU_DRAW), .BUSY(BUSY), .DONE(DONE), .SKIPPED(SKIPPED),
        .ABORTED(ABORTED), .LAST_FRAME(LAST_FRAME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] word_val(input logic f, input logic [10:0] n);
        logic [15:0] v;
        v = {5'b0, n} ^ 16'hA5A5;
        if (f) v = v ^ 16'h5A5A;
        return v;
    endfunction

    logic [15:0] mem [4096];

    // Synchronous-read frame RAM
    always @(posedge CLK) begin
        if (RAM_EN) RAM_DATA_R <= mem[RAM_ADDR];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int          cyc;
    logic        exp_frame;
    logic [10:0] rd_exp, wr_exp;
    int ram_cnt, vram_cnt, draw_cnt, done_cnt, busy_cnt;
    int addr_err, data_err, we_err, qual_err;
    int first_rd, last_rd, first_wr, last_wr, draw_cyc, done_cyc;
    logic [11:0] first_ra, last_ra;
    logic [15:0] first_wa, last_wa;
    logic        skip_at, abort_at;

    task automatic clear_stats(input logic f);
        exp_frame = f; rd_exp = '0; wr_exp = '0;
        ram_cnt = 0; vram_cnt = 0; draw_cnt = 0; done_cnt = 0; busy_cnt = 0;
        addr_err = 0; data_err = 0; we_err = 0; qual_err = 0;
        first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
        draw_cyc = -1; done_cyc = -1;
        first_ra = '0; last_ra = '0; first_wa = '0; last_wa = '0;
        skip_at = 1'b0; abort_at = 1'b0;
    endtask

    task automatic observe();
        if (VRAM_WE !== VRAM_EN) we_err++;
        if (BUSY) busy_cnt++;
        if ((SKIPPED && ABORTED) || ((SKIPPED || ABORTED) && !DONE)) qual_err++;
        if (RAM_EN) begin
            if (ram_cnt == 0) begin first_rd = cyc; first_ra = RAM_ADDR; end
            last_rd = cyc; last_ra = RAM_ADDR;
            if (RAM_ADDR !== {exp_frame, rd_exp}) addr_err++;
            rd_exp++; ram_cnt++;
        end
        if (VRAM_EN) begin
            if (vram_cnt == 0) begin first_wr = cyc; first_wa = VRAM_ADDR; end
            last_wr = cyc; last_wa = VRAM_ADDR;
            if (VRAM_ADDR !== {5'b0, wr_exp}) addr_err++;
            if (VRAM_DATA_W !== word_val(exp_frame, wr_exp)) data_err++;
            wr_exp++; vram_cnt++;
        end
        if (GPU_DRAW) begin draw_cnt++; draw_cyc = cyc; end
        if (DONE) begin done_cnt++; done_cyc = cyc; skip_at = SKIPPED; abort_at = ABORTED; end
    endtask

    // Cycle 0 is the cycle START is presented; inputs change 1 time unit after each edge
    task automatic run_copy(input logic f, input logic g, input int abort_cyc,
                            input logic spam, input int drop_ready_cyc);
        logic got;
        clear_stats(f);
        cyc = 0; FRAME_SEL = f; GPU_READY = g; START = 1'b1; ABORT = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge CLK); observe();
            if (DONE) got = 1'b1;
            @(posedge CLK); #1; cyc++;
            START = spam && !got;
            ABORT = (cyc == abort_cyc);
            if (cyc == drop_ready_cyc) GPU_READY = 1'b0;
        end
        START = 1'b0; ABORT = 1'b0;
        repeat (4) begin
            @(negedge CLK); observe();
            @(posedge CLK); #1; cyc++;
        end
        check("done_seen", got, 1);
    endtask

    task automatic check_clean(input string tag);
        check({tag, "_addr_err"}, addr_err, 0);
        check({tag, "_data_err"}, data_err, 0);
        check({tag, "_we_err"}, we_err, 0);
        check({tag, "_qual_err"}, qual_err, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    function automatic logic [31:0] out_or();
        return {16'b0, RAM_EN, |RAM_ADDR, VRAM_EN, VRAM_WE, |VRAM_ADDR, |VRAM_DATA_W,
                GPU_DRAW, BUSY, DONE, SKIPPED, ABORTED, LAST_FRAME};
    endfunction

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = word_val(a[11], a[10:0]);
        RAM_DATA_R = '0;
        RESET = 1'b1; START = 1'b0; FRAME_SEL = 1'b0; ABORT = 1'b0; GPU_READY = 1'b0;
        cyc = 0;
        clear_stats(1'b0);
        repeat (2) @(negedge CLK);
        check("reset_outputs", out_or(), 0);
        @(posedge CLK); #1; RESET = 1'b0;
        @(posedge CLK); #1;

        // Full copy of frame 0
        run_copy(1'b0, 1'b1, -1, 1'b0, -1);
        check_clean("f0");
        check("f0_done_cyc", done_cyc, 2052);
        check("f0_draw_cnt", draw_cnt, 1);
        check("f0_draw_cyc", draw_cyc, 2052);
        check("f0_skip", skip_at, 0);
        check("f0_abort", abort_at, 0);
        check("f0_reads", ram_cnt, 2048);
        check("f0_writes", vram_cnt, 2048);
        check("f0_first_rd", first_rd, 2);
        check("f0_last_rd", last_rd, 2049);
        check("f0_first_wr", first_wr, 4);
        check("f0_last_wr", last_wr, 2051);
        check("f0_busy_cycles", busy_cnt, 2052);
        check("f0_last_frame", LAST_FRAME, 0);

        // Full copy of frame 1; GPU_READY falling mid-stream is ignored
        run_copy(1'b1, 1'b1, -1, 1'b0, 50);
        check_clean("f1");
        check("f1_done_cyc", done_cyc, 2052);
        check("f1_first_ra", first_ra, 12'h800);
        check("f1_last_ra", last_ra, 12'hFFF);
        check("f1_first_wa", first_wa, 16'h0000);
        check("f1_last_wa", last_wa, 16'h07FF);
        check("f1_writes", vram_cnt, 2048);
        check("f1_draw_cnt", draw_cnt, 1);
        check("f1_last_frame", LAST_FRAME, 1);

        // GPU not ready: skipped in CHECK
        run_copy(1'b0, 1'b0, -1, 1'b0, -1);
        check_clean("skip");
        check("skip_done_cyc", done_cyc, 1);
        check("skip_flag", skip_at, 1);
        check("skip_abort", abort_at, 0);
        check("skip_reads", ram_cnt, 0);
        check("skip_writes", vram_cnt, 0);
        check("skip_draw", draw_cnt, 0);
        check("skip_last_frame", LAST_FRAME, 1);

        // ABORT wins over GPU_READY in CHECK
        run_copy(1'b0, 1'b1, 1, 1'b0, -1);
        check_clean("abchk");
        check("abchk_done_cyc", done_cyc, 1);
        check("abchk_aborted", abort_at, 1);
        check("abchk_skip", skip_at, 0);
        check("abchk_reads", ram_cnt, 0);

        // ABORT in the cycle that would read word 100 (cycle 102)
        run_copy(1'b0, 1'b1, 102, 1'b0, -1);
        check_clean("ab");
        check("ab_done_cyc", done_cyc, 102);
        check("ab_aborted", abort_at, 1);
        check("ab_skip", skip_at, 0);
        check("ab_reads", ram_cnt, 100);
        check("ab_writes", vram_cnt, 98);
        check("ab_last_wa", last_wa, 97);
        check("ab_last_wr", last_wr, 101);
        check("ab_draw", draw_cnt, 0);
        check("ab_last_frame", LAST_FRAME, 1);

        // START held every cycle while busy: one copy only
        run_copy(1'b1, 1'b1, -1, 1'b1, -1);
        check_clean("spam");
        check("spam_done_cyc", done_cyc, 2052);
        check("spam_writes", vram_cnt, 2048);
        check("spam_draw", draw_cnt, 1);
        check("spam_last_frame", LAST_FRAME, 1);

        // Asynchronous reset mid-STREAM
        clear_stats(1'b0);
        cyc = 0; FRAME_SEL = 1'b0; GPU_READY = 1'b1; START = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK); observe();
            @(posedge CLK); #1; cyc++;
            START = 1'b0;
        end
        check("rst_streaming", {RAM_EN, BUSY}, 2'b11);
        #2 RESET = 1'b1;
        #1 check("rst_async_outputs", out_or(), 0);
        @(posedge CLK); #1; RESET = 1'b0;
        clear_stats(1'b0);
        repeat (10) begin
            @(negedge CLK); observe();
            @(posedge CLK); #1;
        end
        check("rst_no_done", done_cnt, 0);
        check("rst_no_reads", ram_cnt, 0);
        check("rst_idle", busy_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
